clock_divider_bank: RTL and testbench
=====================================

// Module: clock_divider_bank
// PURPOSE
//  Parametrised bank of NUM_CH independent clock dividers; next generation of the fixed divide-by-2 divider.
//  Generates the derived processor/regfile/aux clocks from the single input clock.
//  Per-channel runtime divide ratio and enable via valid/ready config port; changes are glitch-free (period boundary).
//  Sync restart re-phases all channels together.
// PARAMETERS
//  NUM_CH   4  number of output channels (>=1)
//  CNT_W    8  width of divide ratio and per-channel counter
//  DEF_DIV  2  divide ratio loaded at reset (2 <= DEF_DIV <= 2^CNT_W-1)
// PORTS
//  clock        in   1               master clock; all logic on rising edge
//  reset        in   1               synchronous, active-low reset (asserted when 0)
//  cfg_valid    in   1               config request
//  cfg_ready    out  1               config accepted when cfg_valid & cfg_ready
//  cfg_ch       in   $clog2(NUM_CH)  target channel (max(1,...) width)
//  cfg_div      in   CNT_W           new divide ratio
//  cfg_en       in   1               new channel enable
//  cfg_err      out  1               1-cycle pulse: request rejected
//  sync_restart in   1               re-phase all channels
//  clk_out      out  NUM_CH          divided clocks (registered)
//  tick         out  NUM_CH          1-cycle pulse at start of each period
// BEHAVIOUR
//  Reset (reset==0 at edge): div=DEF_DIV, en=1, cnt=DEF_DIV-1, clk_out=0, tick=0, pending=0, cfg_err=0.
//  Per channel, enabled: cnt==div-1 -> cnt<=0, tick<=1; else cnt<=cnt+1, tick<=0.
//  clk_out <= (next cnt < hi_len), hi_len=(div+1)>>1; high first ceil(div/2) cycles of each period.
//  Odd div: high one cycle longer than low (div=3 -> 2 high, 1 low).
//  First edge after reset release: all channels wrap to cnt=0, clk_out=1, tick=1 (in phase).
//  Disabled: cnt held at div-1, clk_out=0, tick=0.
//  Config handshake:
//   - cfg_ready = ~pending[cfg_ch] (comb.); 1 for out-of-range cfg_ch.
//   - Accept: cfg_ch<NUM_CH and 2<=cfg_div -> store {cfg_div,cfg_en} in pending slot, set pending.
//   - Reject: cfg_ch>=NUM_CH or cfg_div<2 -> cfg_err=1 next cycle; no state change.
//  Apply pending: edge where channel cnt==div-1 (boundary), or channel disabled (next edge).
//   - On apply: div/en updated, pending cleared, counter follows the enabled/disabled rule with the new values.
//   - Disable via config: takes effect at boundary; clk_out ends low, never a runt pulse.
//   - Enable of a disabled channel: cnt<=0, clk_out=1, tick=1 on apply edge.
//  sync_restart=1: all channels apply pending at this edge, then cnt<=div-1, clk_out<=0, tick<=0.
//   - Counting resumes next edge; all channels start together.
//  Simultaneous events:
//   - Config accepted with sync_restart: stored as pending, applied at the next boundary, not this edge.
//   - reset==0 overrides everything, including mid-period and with pending configs (pending discarded).
//  Never modify div of a running channel mid-period; no combinational path from cfg_* to clk_out/tick.
// TESTING
//  T1 reset=0 3 cycles, release, defaults -> all clk_out toggle every cycle (1,0,1,0); tick every 2nd cycle, in phase.
//  T2 cfg ch1 div=5 at cnt=0 -> ch1 keeps div=2 until its boundary, then 3 high/2 low; cfg_ready low until applied.
//  T3 cfg div=1 on ch0, then cfg_ch=NUM_CH -> cfg_err pulses twice; no clk_out change; cfg_ready stays 1.
//  T4 cfg ch2 en=0 mid-high-phase (div=4) -> ch2 finishes 2H/2L, then held 0; re-enable -> clk_out=1, tick on apply edge.
//  T5 ch0 div=3, ch1 div=4 running, sync_restart 1 cycle -> both clk_out=0 one cycle, then rise together with tick.
//  T6 reset=0 asserted mid-period with pending cfg on ch3 -> next edge reset values; pending gone; DEF_DIV restored.

Source files
------------

// File: rtl/clock_divider_bank.sv
// Bank of NUM_CH independent runtime-configurable clock dividers sharing one master clock.
// Ratio/enable updates are staged per channel and take effect only at a period boundary.
module clock_divider_bank #(
  parameter int NUM_CH  = 4,
  parameter int CNT_W   = 8,
  parameter int DEF_DIV = 2,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  input  logic              cfg_en,
  output logic              cfg_err,
  input  logic              sync_restart,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick
);

  localparam logic [CNT_W-1:0] DEF_DIV_W = CNT_W'(DEF_DIV);
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

  logic [NUM_CH-1:0] cfg_sel;
  logic [NUM_CH-1:0] pending;
  logic              cfg_fire;
  logic              cfg_ok;
  logic              cfg_accept;

  // Out-of-range channels match no slot, so they always see ready and get rejected.
  always_comb begin
    cfg_sel   = '0;
    cfg_ready = 1'b1;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cfg_ch == CH_W'(i)) begin
        cfg_sel[i] = 1'b1;
        cfg_ready  = ~pending[i];
      end
    end
  end

  assign cfg_fire   = cfg_valid & cfg_ready;
  assign cfg_ok     = (|cfg_sel) && (cfg_div >= CNT_W'(2));
  assign cfg_accept = cfg_fire & cfg_ok;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (!reset) cfg_err <= 1'b0;
    else        cfg_err <= cfg_fire & ~cfg_ok;
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [CNT_W-1:0] div_q, cnt_q, pend_div;
    logic [CNT_W-1:0] div_n, cnt_n;
    logic             en_q, pend_q, pend_en, en_n;
    logic             boundary, apply, wrap;
    logic             clk_q, tick_q, clk_n, tick_n;
    logic [CNT_W:0]   hi_len;

    // NOTE: combinational next-state uses blocking assignments with every output defaulted first, so no latches.
    always_comb begin
      boundary = en_q && (cnt_q == div_q - ONE);
      apply    = pend_q && (sync_restart || !en_q || boundary);
      div_n    = apply ? pend_div : div_q;
      en_n     = apply ? pend_en  : en_q;
      // A freshly applied config always opens a new period, including enable-from-idle.
      wrap     = apply || boundary;
      hi_len   = ({1'b0, div_n} + (CNT_W+1)'(1)) >> 1;
      cnt_n    = div_n - ONE;
      clk_n    = 1'b0;
      tick_n   = 1'b0;
      if (!sync_restart && en_n) begin
        cnt_n  = wrap ? '0 : cnt_q + ONE;
        tick_n = wrap;
        clk_n  = {1'b0, cnt_n} < hi_len;
      end
    end

    always_ff @(posedge clock) begin
      if (!reset) begin
        div_q  <= DEF_DIV_W;
        en_q   <= 1'b1;
        cnt_q  <= DEF_DIV_W - ONE;
        clk_q  <= 1'b0;
        tick_q <= 1'b0;
        pend_q <= 1'b0;
      end else begin
        div_q  <= div_n;
        en_q   <= en_n;
        cnt_q  <= cnt_n;
        clk_q  <= clk_n;
        tick_q <= tick_n;
        if (apply)                        pend_q <= 1'b0;
        else if (cfg_accept && cfg_sel[g]) pend_q <= 1'b1;
      end
    end

    // NOTE: the staged payload has no reset; it is only ever read while pend_q (which is reset) is set.
    always_ff @(posedge clock) begin
      if (cfg_accept && cfg_sel[g]) begin
        pend_div <= cfg_div;
        pend_en  <= cfg_en;
      end
    end

    assign clk_out[g] = clk_q;
    assign tick[g]    = tick_q;
    assign pending[g] = pend_q;
  end

endmodule

// File: tb/tb_clock_divider_bank.sv
// Self-checking bench for clock_divider_bank: directed table, corner sequences and
// randomized traffic checked against a period-position reference model.
module tb_clock_divider_bank;

  localparam int NUM_CH  = 5;
  localparam int CNT_W   = 4;
  localparam int DEF_DIV = 2;
  localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              cfg_valid = 1'b0;
  logic              cfg_ready;
  logic [CH_W-1:0]   cfg_ch = '0;
  logic [CNT_W-1:0]  cfg_div = '0;
  logic              cfg_en = 1'b0;
  logic              cfg_err;
  logic              sync_restart = 1'b0;
  logic [NUM_CH-1:0] clk_out;
  logic [NUM_CH-1:0] tick;

  always #5 clock = ~clock;

  clock_divider_bank #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .DEF_DIV(DEF_DIV)) dut (
    .clock(clock), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_ch(cfg_ch), .cfg_div(cfg_div), .cfg_en(cfg_en), .cfg_err(cfg_err),
    .sync_restart(sync_restart), .clk_out(clk_out), .tick(tick)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: each channel tracks its position inside the current period.
  int                m_div[NUM_CH], m_pos[NUM_CH], m_pdiv[NUM_CH];
  bit                m_en[NUM_CH], m_pend[NUM_CH], m_pen[NUM_CH];
  logic [NUM_CH-1:0] m_clk, m_tick;
  bit                m_err;

  function automatic bit m_ready(input int ch);
    if (ch < NUM_CH) return !m_pend[ch];
    return 1'b1;
  endfunction

  task automatic model_step(input bit rst, input bit v, input int ch, input int d, input bit e, input bit s);
    bit fire, ok;
    if (!rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        m_div[i] = DEF_DIV; m_en[i] = 1'b1; m_pos[i] = DEF_DIV - 1; m_pend[i] = 1'b0;
      end
      m_clk = '0; m_tick = '0; m_err = 1'b0;
    end else begin
      fire  = v && m_ready(ch);
      ok    = (ch < NUM_CH) && (d >= 2);
      m_err = fire && !ok;
      for (int i = 0; i < NUM_CH; i++) begin
        bit at_end, fresh;
        at_end = m_en[i] && (m_pos[i] == m_div[i] - 1);
        fresh  = at_end;
        if (m_pend[i] && (s || !m_en[i] || at_end)) begin
          m_div[i] = m_pdiv[i]; m_en[i] = m_pen[i]; m_pend[i] = 1'b0; fresh = 1'b1;
        end
        if (s || !m_en[i]) begin
          m_pos[i] = m_div[i] - 1; m_clk[i] = 1'b0; m_tick[i] = 1'b0;
        end else begin
          m_pos[i]  = fresh ? 0 : m_pos[i] + 1;
          m_tick[i] = (m_pos[i] == 0);
          m_clk[i]  = (2 * m_pos[i] < m_div[i]);
        end
      end
      if (fire && ok) begin
        m_pend[ch] = 1'b1; m_pdiv[ch] = d; m_pen[ch] = e;
      end
    end
  endtask

  // One clock: drive inputs, check ready, advance model, check registered outputs after the edge.
  task automatic step(input bit rst, input bit v, input int ch, input int d, input bit e, input bit s);
    reset = rst; cfg_valid = v; cfg_ch = CH_W'(ch); cfg_div = CNT_W'(d); cfg_en = e; sync_restart = s;
    #1;
    check("cfg_ready", cfg_ready, m_ready(ch));
    model_step(rst, v, ch, d, e, s);
    @(posedge clock);
    #1;
    check("clk_out", clk_out, m_clk);
    check("tick", tick, m_tick);
    check("cfg_err", cfg_err, m_err);
  endtask

  task automatic idle();
    step(1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
  endtask

  typedef struct {
    bit                rst, v;
    int                ch, d;
    bit                e, s;
    logic [NUM_CH-1:0] clk, tk;
    bit                err;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input bit rst, input bit v, input int ch, input int d,
                     input logic [NUM_CH-1:0] clk, input logic [NUM_CH-1:0] tk, input bit err);
    vec_t r;
    r.rst = rst; r.v = v; r.ch = ch; r.d = d; r.e = 1'b1; r.s = 1'b0;
    r.clk = clk; r.tk = tk; r.err = err;
    tbl.push_back(r);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit seen;

    // Reset and default toggling, then rejected configs that must not disturb anything.
    add(0, 0, 0, 0, 5'h00, 5'h00, 0);
    add(0, 0, 0, 0, 5'h00, 5'h00, 0);
    add(1, 0, 0, 0, 5'h1f, 5'h1f, 0);
    add(1, 0, 0, 0, 5'h00, 5'h00, 0);
    add(1, 0, 0, 0, 5'h1f, 5'h1f, 0);
    add(1, 0, 0, 0, 5'h00, 5'h00, 0);
    add(1, 1, 0, 1, 5'h1f, 5'h1f, 1);
    add(1, 1, NUM_CH, 3, 5'h00, 5'h00, 1);
    add(1, 0, 0, 0, 5'h1f, 5'h1f, 0);
    add(1, 1, 7, 0, 5'h00, 5'h00, 1);
    add(1, 0, 0, 0, 5'h1f, 5'h1f, 0);

    model_step(1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
    @(posedge clock);
    #1;
    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].v, tbl[i].ch, tbl[i].d, tbl[i].e, tbl[i].s);
      check("tbl_clk_out", clk_out, tbl[i].clk);
      check("tbl_tick", tick, tbl[i].tk);
      check("tbl_cfg_err", cfg_err, tbl[i].err);
    end

    // Ratio change on ch1 waits for its current period to end.
    step(1, 1, 1, 5, 1, 0);
    check("t2_hold_div2", clk_out[1], 1'b0);
    cfg_valid = 1'b0; cfg_ch = CH_W'(1);
    #1;
    check("t2_ready_low", cfg_ready, 1'b0);
    step(1, 0, 1, 0, 0, 0);
    check("t2_apply_clk", clk_out[1], 1'b1);
    check("t2_apply_tick", tick[1], 1'b1);
    for (int k = 1; k < 10; k++) begin
      idle();
      check("t2_div5_shape", clk_out[1], (k % 5) < 3);
    end

    // Disable ch2 mid-high-phase: period completes, then stays low; re-enable restarts high.
    step(1, 1, 2, 4, 1, 0);
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      idle();
      seen = tick[2];
    end
    check("t4_found_tick", seen, 1'b1);
    step(1, 1, 2, 4, 0, 0);
    check("t4_still_high", clk_out[2], 1'b1);
    for (int k = 0; k < 6; k++) begin
      idle();
      check("t4_low_after_disable", {tick[2], clk_out[2]}, 2'b00);
    end
    step(1, 1, 2, 4, 1, 0);
    check("t4_idle_on_accept", clk_out[2], 1'b0);
    idle();
    check("t4_reenable_clk", clk_out[2], 1'b1);
    check("t4_reenable_tick", tick[2], 1'b1);

    // Sync restart with a config accepted on the same edge.
    step(1, 1, 0, 3, 1, 0);
    step(1, 1, 1, 4, 1, 0);
    for (int k = 0; k < 12; k++) idle();
    step(1, 1, 3, 6, 1, 1);
    check("t5_restart_clk", clk_out, 5'h00);
    check("t5_restart_tick", tick, 5'h00);
    idle();
    check("t5_rise_clk", clk_out, 5'h1f);
    check("t5_rise_tick", tick, 5'h1f);
    for (int k = 1; k < 6; k++) begin
      idle();
      check("t5_ch0_div3", clk_out[0], (k % 3) < 2);
      check("t5_ch1_div4", clk_out[1], (k % 4) < 2);
      check("t5_ch3_div6", clk_out[3], (k % 6) < 3);
    end

    // Reset mid-period discards a pending config.
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      idle();
      seen = tick[3];
    end
    check("t6_found_tick", seen, 1'b1);
    step(1, 1, 3, 7, 0, 0);
    step(0, 0, 3, 0, 0, 0);
    check("t6_reset_clk", clk_out, 5'h00);
    check("t6_reset_tick", tick, 5'h00);
    check("t6_ready_cleared", cfg_ready, 1'b1);
    idle();
    check("t6_def_clk1", clk_out, 5'h1f);
    idle();
    check("t6_def_clk0", clk_out, 5'h00);
    idle();
    check("t6_def_tick", tick, 5'h1f);

    // Randomized traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      step($urandom_range(0, 199) != 0, $urandom_range(0, 2) == 0,
           int'($urandom_range(0, 7)), int'($urandom_range(0, 15)),
           $urandom_range(0, 4) != 0, $urandom_range(0, 39) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
